// File: rtl/score_pkg.sv
// Shared constants for the BCD score keeper: FSM encoding, segment patterns, digit width.
package score_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_t;

    localparam int unsigned BCD_W     = 4;
    localparam logic [7:0]  SEG_BLANK = 8'hFF;
    localparam logic [7:0]  SEG_ZERO  = 8'hC0;

endpackage

// File: rtl/bcd_to_seven_seg.sv
// One BCD digit to an active-low seven-segment byte {dp,g,f,e,d,c,b,a}; dp always off.
module bcd_to_seven_seg
    import score_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [7:0]       seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (bcd)
            4'd0:    seg = SEG_ZERO;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_keeper_bcd.sv
// Serial BCD score accumulator (one digit per cycle) with seven-segment outputs.
// Define SCORE_HIGH_SCORE_EN to add the high-score register and hi_seven_data output.
module score_keeper_bcd
    import score_pkg::*;
#(
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  UPD,
    input  logic [3:0]            N,
    input  logic                  CLR,
    output logic                  Done,
    output logic                  busy,
    output logic                  sat,
`ifdef SCORE_HIGH_SCORE_EN
    output logic [8*DIGITS-1:0]   hi_seven_data,
`endif
    output logic [8*DIGITS-1:0]   seven_data
);

    localparam int unsigned          SW        = DIGITS * BCD_W;
    localparam int unsigned          IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [SW-1:0]        ALL_NINES = {DIGITS{4'h9}};

    state_t           state_q, state_d;
    logic [SW-1:0]    score_q, score_d;
    logic [SW-1:0]    work_q, work_d;
    logic [4:0]       carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             sat_q, sat_d;

    logic [BCD_W-1:0] digit_cur;
    logic [4:0]       sum, sum_mod, carry_new;
    logic [SW-1:0]    work_upd;

    // Units digit can see carry up to 15, so the sum needs five bits.
    always_comb begin
        digit_cur = work_q[idx_q*BCD_W +: BCD_W];
        sum       = {1'b0, digit_cur} + carry_q;
        sum_mod   = sum % 5'd10;
        carry_new = sum / 5'd10;
        work_upd  = work_q;
        work_upd[idx_q*BCD_W +: BCD_W] = sum_mod[3:0];
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        work_d  = work_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sat_d   = sat_q;
        if (CLR) begin
            state_d = StIdle;
            score_d = '0;
            work_d  = '0;
            carry_d = '0;
            idx_d   = '0;
            sat_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (UPD) begin
                        state_d = StAdd;
                        carry_d = {1'b0, N};
                        work_d  = score_q;
                        idx_d   = '0;
                    end
                end
                StAdd: begin
                    work_d  = work_upd;
                    carry_d = carry_new;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = StDone;
                        // Overflow past the top digit clamps to all nines.
                        if (carry_new != 5'd0) begin
                            work_d  = ALL_NINES;
                            score_d = ALL_NINES;
                            sat_d   = 1'b1;
                        end else begin
                            score_d = work_upd;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            score_q <= '0;
            work_q  <= '0;
            carry_q <= '0;
            idx_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sat_q   <= sat_d;
        end
    end

    assign Done = (state_q == StDone);
    assign busy = (state_q != StIdle);
    assign sat  = sat_q;

`ifdef SCORE_HIGH_SCORE_EN
    logic [SW-1:0] hi_score_q;

    // Packed BCD orders the same as binary, so a plain compare is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_score_q <= '0;
        end else if (CLR && (score_q > hi_score_q)) begin
            hi_score_q <= score_q;
        end
    end
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_to_seven_seg u_seg (
            .bcd (score_q[i*BCD_W +: BCD_W]),
            .seg (seven_data[i*8 +: 8])
        );
`ifdef SCORE_HIGH_SCORE_EN
        bcd_to_seven_seg u_hi_seg (
            .bcd (hi_score_q[i*BCD_W +: BCD_W]),
            .seg (hi_seven_data[i*8 +: 8])
        );
`endif
    end

endmodule

// File: tb/tb_score_keeper_bcd.sv
// Self-checking bench for score_keeper_bcd against an integer score model.
module tb_score_keeper_bcd;

    localparam int unsigned DIGITS = 3;
    localparam int          MAXV   = 999;

    logic                  clk;
    logic                  rst;
    logic                  UPD;
    logic [3:0]            N;
    logic                  CLR;
    logic                  Done;
    logic                  busy;
    logic                  sat;
    logic [8*DIGITS-1:0]   seven_data;
`ifdef SCORE_HIGH_SCORE_EN
    logic [8*DIGITS-1:0]   hi_seven_data;
`endif

    score_keeper_bcd #(.DIGITS(DIGITS)) dut (
        .clk           (clk),
        .rst           (rst),
        .UPD           (UPD),
        .N             (N),
        .CLR           (CLR),
        .Done          (Done),
        .busy          (busy),
        .sat           (sat),
`ifdef SCORE_HIGH_SCORE_EN
        .hi_seven_data (hi_seven_data),
`endif
        .seven_data    (seven_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int model_score;
    int model_hi;
    bit model_sat;

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [8*DIGITS-1:0] exp_disp(input int value);
        logic [8*DIGITS-1:0] r;
        int v;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*8 +: 8] = seg_of(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepted update and checks every cycle of it.
    task automatic do_update(input int n);
        int old_v;
        int new_v;
        bit new_sat;
        old_v   = model_score;
        new_v   = old_v + n;
        new_sat = model_sat;
        if (new_v > MAXV) begin
            new_v   = MAXV;
            new_sat = 1'b1;
        end
        UPD = 1'b1;
        N   = 4'(n);
        step();
        UPD = 1'b0;
        checks++;
        if (busy !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL upd_start: busy=%b Done=%b required busy=1 Done=0", busy, Done);
        end
        for (int k = 1; k < DIGITS; k++) begin
            step();
            checks++;
            if (Done !== 1'b0 || seven_data !== exp_disp(old_v)) begin
                errors++;
                $display("FAIL upd_mid: Done=%b disp=%h required Done=0 disp=%h",
                         Done, seven_data, exp_disp(old_v));
            end
        end
        step();
        model_score = new_v;
        model_sat   = new_sat;
        checks++;
        if (Done !== 1'b1 || seven_data !== exp_disp(new_v) || sat !== new_sat) begin
            errors++;
            $display("FAIL upd_commit: Done=%b disp=%h sat=%b required Done=1 disp=%h sat=%b",
                     Done, seven_data, sat, exp_disp(new_v), new_sat);
        end
        step();
        checks++;
        if (Done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL upd_end: Done=%b busy=%b required 0 0", Done, busy);
        end
    endtask

    task automatic do_clear();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        if (model_score > model_hi) model_hi = model_score;
        model_score = 0;
        model_sat   = 1'b0;
        checks++;
        if (seven_data !== exp_disp(0) || sat !== 1'b0 || busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL clear: disp=%h sat=%b busy=%b Done=%b required %h 0 0 0",
                     seven_data, sat, busy, Done, exp_disp(0));
        end
`ifdef SCORE_HIGH_SCORE_EN
        checks++;
        if (hi_seven_data !== exp_disp(model_hi)) begin
            errors++;
            $display("FAIL hi_score: hi_disp=%h required %h", hi_seven_data, exp_disp(model_hi));
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        model_score = 0;
        model_sat   = 1'b0;
        model_hi    = 0;
        checks++;
        if (seven_data !== 24'hC0C0C0 || Done !== 1'b0 || busy !== 1'b0 || sat !== 1'b0) begin
            errors++;
            $display("FAIL reset: disp=%h Done=%b busy=%b sat=%b required C0C0C0 0 0 0",
                     seven_data, Done, busy, sat);
        end
`ifdef SCORE_HIGH_SCORE_EN
        checks++;
        if (hi_seven_data !== 24'hC0C0C0) begin
            errors++;
            $display("FAIL reset_hi: hi_disp=%h required C0C0C0", hi_seven_data);
        end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        do_clear();
        repeat (3) do_update(5);
        checks++;
        if (seven_data !== exp_disp(15)) begin
            errors++;
            $display("FAIL basic_015: disp=%h required %h", seven_data, exp_disp(15));
        end
    endtask

    task automatic test_carry();
        do_clear();
        repeat (6) do_update(15);
        do_update(5);
        do_update(15);
        checks++;
        if (seven_data !== exp_disp(110)) begin
            errors++;
            $display("FAIL carry_110: disp=%h required %h", seven_data, exp_disp(110));
        end
        do_clear();
        repeat (66) do_update(15);
        do_update(9);
        do_update(0);
        checks++;
        if (seven_data !== exp_disp(999) || sat !== 1'b0) begin
            errors++;
            $display("FAIL full_999: disp=%h sat=%b required %h 0", seven_data, sat, exp_disp(999));
        end
    endtask

    task automatic test_saturate();
        do_clear();
        repeat (66) do_update(15);
        do_update(15);
        checks++;
        if (sat !== 1'b1 || seven_data !== exp_disp(999)) begin
            errors++;
            $display("FAIL sat_set: sat=%b disp=%h required 1 %h", sat, seven_data, exp_disp(999));
        end
        do_update(0);
        do_update(3);
        do_clear();
        do_update(1);
    endtask

    task automatic test_ignore_busy();
        int dones;
        int n;
        n     = int'($urandom_range(1, 15));
        dones = 0;
        UPD = 1'b1;
        N   = 4'(n);
        step();
        N = 4'd9;
        for (int k = 1; k <= DIGITS + 3; k++) begin
            if (k == DIGITS + 2) UPD = 1'b0;
            step();
            if (Done === 1'b1) dones++;
        end
        UPD = 1'b0;
        model_score = (model_score + n > MAXV) ? MAXV : model_score + n;
        checks++;
        if (dones != 1 || seven_data !== exp_disp(model_score) || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy: dones=%0d disp=%h busy=%b required 1 %h 0",
                     dones, seven_data, busy, exp_disp(model_score));
        end
    endtask

    task automatic test_clr_mid();
        int dones;
        dones = 0;
        UPD = 1'b1;
        N   = 4'd7;
        step();
        UPD = 1'b0;
        step();
        do_clear();
        for (int k = 0; k < DIGITS + 2; k++) begin
            step();
            if (Done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || seven_data !== exp_disp(0)) begin
            errors++;
            $display("FAIL clr_mid: activity=%0d disp=%h required 0 %h", dones, seven_data,
                     exp_disp(0));
        end
        UPD = 1'b1;
        N   = 4'd4;
        CLR = 1'b1;
        step();
        UPD = 1'b0;
        CLR = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_with_upd: busy=%b required 0", busy);
        end
    endtask

    task automatic test_rst_mid();
        int dones;
        dones = 0;
        do_update(8);
        UPD = 1'b1;
        N   = 4'd3;
        step();
        UPD = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_score = 0;
        model_sat   = 1'b0;
        model_hi    = 0;
        for (int k = 0; k < DIGITS + 2; k++) begin
            step();
            if (Done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || seven_data !== exp_disp(0)) begin
            errors++;
            $display("FAIL rst_mid: activity=%0d disp=%h required 0 %h", dones, seven_data,
                     exp_disp(0));
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) == 0) do_clear();
            else do_update(int'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_high_score();
        test_reset();
        do_update(15);
        do_update(15);
        do_update(12);
        do_clear();
        do_update(17 - 15);
        do_update(15);
        do_clear();
`ifdef SCORE_HIGH_SCORE_EN
        checks++;
        if (hi_seven_data !== exp_disp(42)) begin
            errors++;
            $display("FAIL hi_keep_042: hi_disp=%h required %h", hi_seven_data, exp_disp(42));
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        UPD    = 1'b0;
        N      = 4'd0;
        CLR    = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_saturate();
        test_ignore_busy();
        test_clr_mid();
        test_rst_mid();
        test_random();
        test_high_score();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
